// File: rtl/neo_frame_sequencer_pkg.sv
// Shared types for the NeoPixel frame sequencer: pixel colour layout and sequencer FSM states.
package neopix_pkg;

  localparam int unsigned NEO_COLOR_W = 24;

  // Wire order on the strip is G, R, B.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } color_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StSetup,
    StLoad,
    StGo,
    StWaitLow,
    StWaitHigh
  } seq_state_t;

endpackage

// File: rtl/neo_frame_sequencer_if.sv
// Pixel write port plus driver load/go/ready handshake of the frame sequencer.
interface neo_frame_sequencer_if #(
  parameter int unsigned NUM_PIXELS = 8
);
  import neopix_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_PIXELS);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  color_t           wr_color;
  logic             commit;
  logic             overrun_clr;
  logic             drv_ready;
  logic             drv_load;
  logic             drv_go;
  logic [IDX_W-1:0] drv_index;
  color_t           drv_color;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  // master: game logic and strip driver side; slave: the sequencer
  modport master (
    output wr_en, wr_addr, wr_color, commit, overrun_clr, drv_ready,
    input  drv_load, drv_go, drv_index, drv_color, busy, frame_done, overrun
  );

  modport slave (
    input  wr_en, wr_addr, wr_color, commit, overrun_clr, drv_ready,
    output drv_load, drv_go, drv_index, drv_color, busy, frame_done, overrun
  );

endinterface

// File: rtl/neo_frame_sequencer_timer.sv
// Free-running frame timer: counts 0..FRAME_TICKS-1 and pulses tick for one cycle after each wrap.
module neo_frame_timer #(
  parameter int unsigned FRAME_TICKS = 833_333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int unsigned CNT_W = $clog2(FRAME_TICKS);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_TICKS - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (count_q == LastCnt);
      count_q <= (count_q == LastCnt) ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/neo_frame_sequencer.sv
// Replays the pixel buffer to the NeoPixel driver as whole frames on each timer wrap or commit.
// Define NEOSEQ_DOUBLE_BUFFER_EN to read frames from a snapshot taken when the frame starts.
module neo_frame_sequencer
  import neopix_pkg::*;
#(
  parameter int unsigned NUM_PIXELS  = 8,
  parameter int unsigned FRAME_TICKS = 833_333
) (
  input logic                  clock,
  input logic                  reset,
  neo_frame_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_PIXELS);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PIXELS - 1);

  seq_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             pending_q;
  logic             tick;
  logic             trigger;
  logic             start;
  color_t           buffer_q [NUM_PIXELS];
  color_t           frame_px;

  neo_frame_timer #(
    .FRAME_TICKS(FRAME_TICKS)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // A timer wrap coinciding with commit is a single trigger.
  assign trigger = tick | bus.commit;
  assign start   = (state_q == StIdle) && (trigger || pending_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PIXELS; i++) buffer_q[i] <= '0;
    end else if (bus.wr_en && (32'(bus.wr_addr) < NUM_PIXELS)) begin
      buffer_q[bus.wr_addr] <= bus.wr_color;
    end
  end

`ifdef NEOSEQ_DOUBLE_BUFFER_EN
  color_t snap_q [NUM_PIXELS];

  // Copy happens on the same edge as any write, so the snapshot holds the pre-write value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PIXELS; i++) snap_q[i] <= '0;
    end else if (start) begin
      snap_q <= buffer_q;
    end
  end

  assign frame_px = snap_q[idx_q];
`else
  assign frame_px = buffer_q[idx_q];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      bus.drv_load   <= 1'b0;
      bus.drv_go     <= 1'b0;
      bus.drv_index  <= '0;
      bus.drv_color  <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.drv_load   <= 1'b0;
      bus.drv_go     <= 1'b0;
      bus.frame_done <= 1'b0;

      // A new overrun event wins over a simultaneous clear.
      if (bus.overrun_clr) bus.overrun <= 1'b0;
      if ((state_q != StIdle) && trigger) begin
        if (pending_q) bus.overrun <= 1'b1;
        else           pending_q   <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            pending_q <= 1'b0;
            bus.busy  <= 1'b1;
            state_q   <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (bus.drv_ready) begin
            idx_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          bus.drv_index <= idx_q;
          bus.drv_color <= frame_px;
          bus.drv_load  <= 1'b1;
          state_q       <= StLoad;
        end
        StLoad: begin
          if (idx_q == LastIdx) begin
            bus.drv_go <= 1'b1;
            state_q    <= StGo;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= StSetup;
          end
        end
        StGo: begin
          state_q <= StWaitLow;
        end
        StWaitLow: begin
          if (!bus.drv_ready) state_q <= StWaitHigh;
        end
        StWaitHigh: begin
          if (bus.drv_ready) begin
            bus.frame_done <= 1'b1;
            bus.busy       <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Randomized self-checking bench for neo_frame_sequencer against a frame-level reference model.
module tb_neo_frame_sequencer;
  import neopix_pkg::*;

  localparam int unsigned NPix      = 8;
  localparam int unsigned IdxW      = $clog2(NPix);
  localparam int unsigned FastTicks = 64;

  typedef struct {
    int unsigned idx;
    logic [23:0] color;
    int          at;
  } load_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  neo_frame_sequencer_if #(.NUM_PIXELS(NPix)) bus ();
  neo_frame_sequencer_if #(.NUM_PIXELS(NPix)) bus2 ();

  neo_frame_sequencer #(.NUM_PIXELS(NPix)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  neo_frame_sequencer #(.NUM_PIXELS(NPix), .FRAME_TICKS(FastTicks)) dut_fast (
    .clock(clock),
    .reset(reset),
    .bus  (bus2)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  load_t       loads[$];
  int          go_cyc[$];
  int          go2_cyc[$];
  int          done_cnt = 0;
  int          done2_cnt = 0;
  bit          force_low = 1'b0;
  int          low_len = 5;
  logic [23:0] model_buf [NPix];

  always @(posedge clock) cyc++;

  // Event monitor, sampled mid-cycle.
  always @(negedge clock) begin
    load_t e;
    if (bus.drv_load) begin
      e.idx   = int'(bus.drv_index);
      e.color = bus.drv_color;
      e.at    = cyc;
      loads.push_back(e);
    end
    if (bus.drv_go) go_cyc.push_back(cyc);
    if (bus.frame_done) done_cnt++;
    if (bus2.drv_go) go2_cyc.push_back(cyc);
    if (bus2.frame_done) done2_cnt++;
  end

  // Strip driver models: ready drops 2 cycles after go, stays low a while, then returns.
  initial begin
    bus.drv_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (force_low) bus.drv_ready = 1'b0;
      else if (bus.drv_go) begin
        repeat (2) @(negedge clock);
        bus.drv_ready = 1'b0;
        repeat (low_len) @(negedge clock);
        bus.drv_ready = 1'b1;
      end
    end
  end

  initial begin
    bus2.drv_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (bus2.drv_go) begin
        repeat (2) @(negedge clock);
        bus2.drv_ready = 1'b0;
        repeat (4) @(negedge clock);
        bus2.drv_ready = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic write_px(input int unsigned a, input logic [23:0] c);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = IdxW'(a);
    bus.wr_color = c;
    step();
    bus.wr_en    = 1'b0;
    model_buf[a] = c;
  endtask

  task automatic do_commit(output int at);
    bus.commit = 1'b1;
    at = cyc;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int n = 0; n < 400 && done_cnt < target; n++) step();
    check(tag, done_cnt, target);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic wait_load(input int unsigned idx, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      step();
      if (loads.size() > 0 && loads[$].idx == idx && loads[$].at == cyc) seen = 1'b1;
    end
  endtask

  // A frame is NPix loads in index order, 2 cycles apart, then one go a cycle after the last.
  task automatic check_frame(input string tag, input logic [23:0] exp [NPix], input int first_at);
    check({tag, "_nloads"}, loads.size(), NPix);
    for (int i = 0; i < int'(NPix) && i < loads.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), loads[i].idx, i);
      check($sformatf("%s_color%0d", tag, i), loads[i].color, exp[i]);
      check($sformatf("%s_at%0d", tag, i), loads[i].at, first_at + 2 * i);
    end
    check({tag, "_ngo"}, go_cyc.size(), 1);
    if (go_cyc.size() > 0) check({tag, "_go_at"}, go_cyc[0], first_at + 2 * NPix - 1);
  endtask

  initial begin
    int          t;
    int          r;
    int          r0;
    int          prev;
    bit          seen;
    logic [23:0] exp_f [NPix];

    bus.wr_en = 1'b0;  bus.wr_addr = '0;  bus.wr_color = '0;
    bus.commit = 1'b0; bus.overrun_clr = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_color = '0;
    bus2.commit = 1'b0; bus2.overrun_clr = 1'b0;
    for (int i = 0; i < int'(NPix); i++) model_buf[i] = '0;

    step(3);
    check("rst_load", bus.drv_load, 1'b0);
    check("rst_go", bus.drv_go, 1'b0);
    check("rst_index", bus.drv_index, '0);
    check("rst_color", bus.drv_color, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.frame_done, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    reset = 1'b0;
    step(2);

    // Directed frame with ready held high at the trigger.
    for (int i = 0; i < int'(NPix); i++) write_px(i, 24'h010000 * (i + 1));
    exp_f = model_buf;
    loads.delete(); go_cyc.delete();
    prev = done_cnt;
    do_commit(t);
    wait_done("basic_done", prev + 1);
    check_frame("basic", exp_f, t + 3);

    // Driver busy at commit: nothing loads until ready rises.
    force_low = 1'b1;
    bus.drv_ready = 1'b0;
    step();
    loads.delete(); go_cyc.delete();
    prev = done_cnt;
    do_commit(t);
    step(20);
    check("notready_loads", loads.size(), 0);
    force_low = 1'b0;
    bus.drv_ready = 1'b1;
    r = cyc;
    wait_done("notready_done", prev + 1);
    check_frame("notready", exp_f, r + 2);

    // Two commits during a frame: one extra frame, overrun set, clear loses to a new event.
    loads.delete(); go_cyc.delete();
    prev = done_cnt;
    do_commit(t);
    step(3);
    do_commit(t);
    check("ovr_after_pending", bus.overrun, 1'b0);
    step(2);
    do_commit(t);
    check("ovr_set", bus.overrun, 1'b1);
    bus.overrun_clr = 1'b1;
    do_commit(t);
    bus.overrun_clr = 1'b0;
    check("ovr_clr_vs_event", bus.overrun, 1'b1);
    wait_done("ovr_done2", prev + 2);
    step(60);
    check("ovr_frames", done_cnt - prev, 2);
    check("ovr_ngo", go_cyc.size(), 2);
    check("ovr_nloads", loads.size(), 2 * NPix);
    bus.overrun_clr = 1'b1;
    step();
    bus.overrun_clr = 1'b0;
    check("ovr_cleared", bus.overrun, 1'b0);

    // Write to the last pixel while pixel 2 is being loaded.
    exp_f = model_buf;
`ifndef NEOSEQ_DOUBLE_BUFFER_EN
    exp_f[NPix-1] = 24'hFFFFFF;
`endif
    loads.delete(); go_cyc.delete();
    prev = done_cnt;
    do_commit(t);
    wait_load(2, seen);
    check("tear_load2_seen", seen, 1'b1);
    write_px(NPix - 1, 24'hFFFFFF);
    wait_done("tear_done", prev + 1);
    check_frame("tear", exp_f, t + 3);
    exp_f = model_buf;
    loads.delete(); go_cyc.delete();
    prev = done_cnt;
    do_commit(t);
    wait_done("tear_next_done", prev + 1);
    check_frame("tear_next", exp_f, t + 3);

    // Random writes between frames, random driver recovery time.
    for (int it = 0; it < 8; it++) begin
      low_len = int'($urandom_range(1, 8));
      for (int w = 0; w < int'($urandom_range(0, 6)); w++)
        write_px($urandom_range(0, NPix - 1), 24'($urandom));
      step(int'($urandom_range(0, 5)));
      exp_f = model_buf;
      loads.delete(); go_cyc.delete();
      prev = done_cnt;
      do_commit(t);
      wait_done($sformatf("rnd%0d_done", it), prev + 1);
      check_frame($sformatf("rnd%0d", it), exp_f, t + 3);
    end

    // Reset mid-frame with a pending trigger and overrun set.
    low_len = 5;
    loads.delete(); go_cyc.delete();
    do_commit(t);
    step(2);
    do_commit(t);
    step(2);
    do_commit(t);
    check("midrst_ovr_before", bus.overrun, 1'b1);
    wait_load(4, seen);
    check("midrst_load4_seen", seen, 1'b1);
    reset = 1'b1;
    step();
    check("midrst_load", bus.drv_load, 1'b0);
    check("midrst_go", bus.drv_go, 1'b0);
    check("midrst_index", bus.drv_index, '0);
    check("midrst_color", bus.drv_color, '0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.frame_done, 1'b0);
    check("midrst_overrun", bus.overrun, 1'b0);
    reset = 1'b0;
    r0 = cyc;
    go2_cyc.delete();
    done2_cnt = 0;
    loads.delete(); go_cyc.delete();
    for (int i = 0; i < int'(NPix); i++) model_buf[i] = '0;
    step(80);
    check("postrst_nloads", loads.size(), 0);
    check("postrst_ngo", go_cyc.size(), 0);
    check("postrst_busy", bus.busy, 1'b0);

    // Buffer was cleared by reset.
    exp_f = model_buf;
    prev = done_cnt;
    do_commit(t);
    wait_done("zero_done", prev + 1);
    check_frame("zero", exp_f, t + 3);

    // Fast-timer instance: a frame every FastTicks cycles, first wrap FastTicks after reset.
    while (cyc < r0 + 10 * FastTicks + 40) step();
    check("timer_ngo", go2_cyc.size(), 10);
    check("timer_ndone", done2_cnt, 10);
    for (int j = 0; j < 10 && j < go2_cyc.size(); j++)
      check($sformatf("timer_go%0d", j), go2_cyc[j], r0 + FastTicks * (j + 1) + 2 * NPix + 2);
    check("timer_overrun", bus2.overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
